// File: rtl/pad_bus_if.sv
// pad_bus_if: word-aligned external memory request/acknowledge bus.
interface pad_bus_if;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic        mem_request;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;
    logic        mem_ack;
    modport master (
        output mem_address, mem_byte_enable, mem_write_data, mem_request, mem_write_enable,
        input  mem_read_data, mem_ack
    );
    modport slave (
        input  mem_address, mem_byte_enable, mem_write_data, mem_request, mem_write_enable,
        output mem_read_data, mem_ack
    );
endinterface

// File: rtl/pad_bus_interface.sv
// pad_bus_interface: turns phase-timed pad strobes into a memory request/ack transaction
// with lane steering, store replication, load extension, stall and timeout.
module pad_bus_interface #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    input  logic        pad_write_address,
    input  logic        pad_read,
    input  logic        pad_write,
    input  logic [1:0]  pad_data_size,
    input  logic        load_unsigned,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        stall,
    output logic        misaligned,
    output logic        timeout,
    pad_bus_if.master   mem
);
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT} state_t;
    localparam logic [7:0] MAX_W = 8'(MAX_WAIT);
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  count_q, count_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        timeout_q, timeout_d;
    logic [31:0] eff_addr, shifted, ext;
    logic        idle, start, bad, accept, done, expire;
    always_comb begin
        idle     = state_q == IDLE;
        eff_addr = pad_write_address ? address_in : addr_q;
        start    = idle & (pad_write | pad_read);
        bad      = pad_data_size[1] ? |eff_addr[1:0] : pad_data_size[0] & eff_addr[0];
        accept   = start & !bad;
        done     = !idle & mem.mem_ack;
        expire   = !idle & !mem.mem_ack & (count_q == MAX_W);
        stall    = accept | (!idle & !mem.mem_ack);
        // halves are 2-byte aligned here, so a byte-granular shift also serves them
        shifted  = mem.mem_read_data >> {addr_q[1:0], 3'b000};
        ext      = size_q[1] ? mem.mem_read_data :
                   size_q[0] ? {{16{!uns_q & shifted[15]}}, shifted[15:0]} :
                               {{24{!uns_q & shifted[7]}}, shifted[7:0]};
    end
    always_comb begin
        state_d      = state_q;
        addr_d       = (idle & pad_write_address) ? address_in : addr_q;
        count_d      = count_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        misaligned_d = start & bad;
        timeout_d    = 1'b0;
        if (accept) begin
            state_d = pad_write ? WRITE_WAIT : READ_WAIT;
            count_d = '0;
            size_d  = pad_data_size;
            uns_d   = load_unsigned;
            be_d    = pad_data_size[1] ? 4'b1111 :
                      pad_data_size[0] ? 4'b0011 << {eff_addr[1], 1'b0} :
                                         4'b0001 << eff_addr[1:0];
            wdata_d = pad_data_size[1] ? write_data_in :
                      pad_data_size[0] ? {2{write_data_in[15:0]}} :
                                         {4{write_data_in[7:0]}};
        end else if (done) begin
            state_d = IDLE;
            if (state_q == READ_WAIT) begin
                read_data_d  = ext;
                read_valid_d = 1'b1;
            end
        end else if (expire) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            if (state_q == READ_WAIT) read_data_d = '0;
        end else if (!idle) begin
            count_d = count_q + 8'd1;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            count_q      <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end
    assign read_data            = read_data_q;
    assign read_valid           = read_valid_q;
    assign misaligned           = misaligned_q;
    assign timeout              = timeout_q;
    assign mem.mem_address      = {addr_q[31:2], 2'b00};
    assign mem.mem_byte_enable  = be_q;
    assign mem.mem_write_data   = wdata_q;
    assign mem.mem_request      = state_q != IDLE;
    assign mem.mem_write_enable = state_q == WRITE_WAIT;
endmodule

// File: tb/tb_pad_bus_interface.sv
// tb_pad_bus_interface: directed checks of pad_bus_interface with MAX_WAIT = 4.
module tb_pad_bus_interface;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_in, write_data_in;
    logic        pad_write_address, pad_read, pad_write, load_unsigned;
    logic [1:0]  pad_data_size;
    logic [31:0] read_data;
    logic        read_valid, stall, misaligned, timeout;
    int checks = 0;
    int errors = 0;
    pad_bus_if bus();
    pad_bus_interface #(.MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset), .address_in(address_in), .write_data_in(write_data_in),
        .pad_write_address(pad_write_address), .pad_read(pad_read), .pad_write(pad_write),
        .pad_data_size(pad_data_size), .load_unsigned(load_unsigned), .read_data(read_data),
        .read_valid(read_valid), .stall(stall), .misaligned(misaligned), .timeout(timeout),
        .mem(bus)
    );
    always #5 clock = ~clock;
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic start(input logic [31:0] a, input logic [1:0] sz, input logic uns,
                         input logic rd, input logic wr);
        address_in = a; pad_data_size = sz; load_unsigned = uns;
        pad_write_address = 1'b1; pad_read = rd; pad_write = wr;
    endtask
    task automatic idle_pads();
        pad_write_address = 1'b0; pad_read = 1'b0; pad_write = 1'b0;
    endtask
    initial begin
        reset = 1'b1; address_in = '0; write_data_in = '0; load_unsigned = 1'b0;
        pad_data_size = 2'b00; idle_pads();
        bus.mem_ack = 1'b0; bus.mem_read_data = '0;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_read_valid", {31'b0, read_valid}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_request", {31'b0, bus.mem_request}, 32'h0);
        chk("rst_address", bus.mem_address, 32'h0);
        chk("rst_be", {28'b0, bus.mem_byte_enable}, 32'h0);
        // signed byte load, two wait cycles before ack
        start(32'h0000_1003, 2'b00, 1'b0, 1'b1, 1'b0);
        #1 chk("b_accept_stall", {31'b0, stall}, 32'h1);
        cyc(); idle_pads(); load_unsigned = 1'b1;
        chk("b_request", {31'b0, bus.mem_request}, 32'h1);
        chk("b_address", bus.mem_address, 32'h0000_1000);
        chk("b_be", {28'b0, bus.mem_byte_enable}, 32'h8);
        chk("b_we", {31'b0, bus.mem_write_enable}, 32'h0);
        chk("b_wait1_stall", {31'b0, stall}, 32'h1);
        cyc();
        chk("b_wait2_stall", {31'b0, stall}, 32'h1);
        bus.mem_ack = 1'b1; bus.mem_read_data = 32'h80FF_FF7F;
        #1 chk("b_ack_stall", {31'b0, stall}, 32'h0);
        cyc(); bus.mem_ack = 1'b0;
        chk("b_read_data", read_data, 32'hFFFF_FF80);
        chk("b_read_valid", {31'b0, read_valid}, 32'h1);
        chk("b_request_end", {31'b0, bus.mem_request}, 32'h0);
        cyc();
        chk("b_valid_pulse", {31'b0, read_valid}, 32'h0);
        // unsigned half load with immediate ack
        start(32'h0000_2002, 2'b01, 1'b1, 1'b1, 1'b0);
        cyc(); idle_pads(); load_unsigned = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_read_data = 32'hBEEF_1234;
        chk("h_be", {28'b0, bus.mem_byte_enable}, 32'hC);
        #1 chk("h_stall", {31'b0, stall}, 32'h0);
        cyc(); bus.mem_ack = 1'b0;
        chk("h_read_data", read_data, 32'h0000_BEEF);
        chk("h_read_valid", {31'b0, read_valid}, 32'h1);
        // byte store, read also asserted to exercise write priority
        write_data_in = 32'h0000_00A5;
        start(32'h0000_0041, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc(); idle_pads(); write_data_in = 32'h0;
        chk("s_we", {31'b0, bus.mem_write_enable}, 32'h1);
        chk("s_be", {28'b0, bus.mem_byte_enable}, 32'h2);
        chk("s_wdata", bus.mem_write_data, 32'hA5A5_A5A5);
        chk("s_address", bus.mem_address, 32'h0000_0040);
        bus.mem_ack = 1'b1;
        cyc(); bus.mem_ack = 1'b0;
        chk("s_no_valid", {31'b0, read_valid}, 32'h0);
        chk("s_request_end", {31'b0, bus.mem_request}, 32'h0);
        chk("s_read_data_kept", read_data, 32'h0000_BEEF);
        // ack while idle is ignored
        bus.mem_ack = 1'b1;
        cyc(); bus.mem_ack = 1'b0;
        chk("idle_ack_valid", {31'b0, read_valid}, 32'h0);
        chk("idle_ack_request", {31'b0, bus.mem_request}, 32'h0);
        // misaligned word read
        start(32'h0000_0102, 2'b11, 1'b0, 1'b1, 1'b0);
        #1 chk("m_stall", {31'b0, stall}, 32'h0);
        cyc(); idle_pads();
        chk("m_pulse", {31'b0, misaligned}, 32'h1);
        chk("m_request", {31'b0, bus.mem_request}, 32'h0);
        chk("m_read_data", read_data, 32'h0000_BEEF);
        cyc();
        chk("m_pulse_end", {31'b0, misaligned}, 32'h0);
        chk("m_request2", {31'b0, bus.mem_request}, 32'h0);
        // timeout: request held for MAX_WAIT+1 cycles then aborted
        start(32'h0000_0200, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc(); idle_pads();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t_request_%0d", i), {31'b0, bus.mem_request}, 32'h1);
            chk($sformatf("t_no_timeout_%0d", i), {31'b0, timeout}, 32'h0);
            cyc();
        end
        chk("t_pulse", {31'b0, timeout}, 32'h1);
        chk("t_request_end", {31'b0, bus.mem_request}, 32'h0);
        chk("t_read_data", read_data, 32'h0);
        chk("t_no_valid", {31'b0, read_valid}, 32'h0);
        cyc();
        chk("t_pulse_end", {31'b0, timeout}, 32'h0);
        // ack in the final allowed cycle completes
        start(32'h0000_0300, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc(); idle_pads();
        for (int i = 0; i < 4; i++) cyc();
        chk("l_request", {31'b0, bus.mem_request}, 32'h1);
        bus.mem_ack = 1'b1; bus.mem_read_data = 32'h1234_5678;
        cyc(); bus.mem_ack = 1'b0;
        chk("l_no_timeout", {31'b0, timeout}, 32'h0);
        chk("l_read_valid", {31'b0, read_valid}, 32'h1);
        chk("l_read_data", read_data, 32'h1234_5678);
        // reset in the second wait cycle
        start(32'h0000_0010, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc(); idle_pads();
        cyc();
        reset = 1'b1;
        cyc(); reset = 1'b0;
        chk("r_request", {31'b0, bus.mem_request}, 32'h0);
        chk("r_stall", {31'b0, stall}, 32'h0);
        chk("r_valid", {31'b0, read_valid}, 32'h0);
        chk("r_timeout", {31'b0, timeout}, 32'h0);
        // follow-up read at 0x0, size 10 behaves as word
        start(32'h0000_0000, 2'b10, 1'b0, 1'b1, 1'b0);
        cyc(); idle_pads();
        chk("r2_be", {28'b0, bus.mem_byte_enable}, 32'hF);
        bus.mem_ack = 1'b1; bus.mem_read_data = 32'hCAFE_F00D;
        cyc(); bus.mem_ack = 1'b0;
        chk("r2_read_data", read_data, 32'hCAFE_F00D);
        chk("r2_read_valid", {31'b0, read_valid}, 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pad_bus_interface.md
Name: pad_bus_interface

Overview:
- Sits directly downstream of the operation controller's output-interface signals: pad_write_address, pad_read, pad_write and pad_data_size.
- Converts those phase-timed strobes into a word-aligned external memory request/acknowledge transaction.
- Handles byte-lane steering, store replication and load sign/zero extension.
- Raises stall to freeze the phase generator until the memory answers or a timeout expires.

Parameters:
MAX_WAIT, 16, wait cycles allowed after request before abort (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
address_in  in  32  byte address from address bus
write_data_in  in  32  store data (unshifted, LSB-aligned)
pad_write_address  in  1  latch address_in
pad_read  in  1  start read
pad_write  in  1  start write
pad_data_size  in  2  00 byte, 01 half, 11 word (10 treated as word)
load_unsigned  in  1  zero-extend instead of sign-extend
read_data  out  32  extended load result, held until next read completes or aborts
read_valid  out  1  one-cycle pulse, read_data updated
stall  out  1  freeze phase generator
misaligned  out  1  one-cycle pulse, access rejected
timeout  out  1  one-cycle pulse, access aborted
mem_address  out  32  {address_reg[31:2], 2'b00}
mem_byte_enable  out  4  active lanes
mem_write_data  out  32  lane-replicated store data
mem_request  out  1  transaction active
mem_write_enable  out  1  1 = write
mem_read_data  in  32  memory word
mem_ack  in  1  memory completes current request

Behaviour:
- Reset and interface: reset and clock as already decided (reset synchronous, active-high; clock clock).
- Reset state: all outputs, address_reg, wait counter and state are 0; state = IDLE.
- Address latch:
  - address_reg loads address_in on any edge where pad_write_address = 1 and state = IDLE.
  - An access started in the same cycle uses address_in directly (bypass).
- States: IDLE, READ_WAIT, WRITE_WAIT.
- Accept (IDLE only): pad_write = 1 starts a write; else pad_read = 1 starts a read. Write has priority when both are asserted.
- Misalignment check at accept:
  - Half with addr[0] = 1, or word with addr[1:0] != 0, is misaligned.
  - Misaligned access: misaligned pulses the next cycle; no request; state stays IDLE; read_data unchanged.
- Aligned accept:
  - Next edge: state moves to READ_WAIT or WRITE_WAIT; mem_request = 1; mem_write_enable set for writes; lanes and data registered; wait counter = 0.
- stall = accept_aligned | (state != IDLE) & !mem_ack. Combinational; phase holds from the accept cycle until the ack cycle inclusive of accept, exclusive of ack.
- Lane rules (lane = addr[1:0]):
  - Byte: enable = 0001 << lane; store data = {4{wd[7:0]}}.
  - Half: enable = 0011 << (2*addr[1]); store data = {2{wd[15:0]}}.
  - Word: enable = 1111; store data = wd.
- Wait states:
  - Each cycle in a WAIT state with mem_ack = 0 increments the counter.
  - mem_request, mem_address, mem_byte_enable, mem_write_data and mem_write_enable stay constant until the transaction ends.
- Completion (mem_ack = 1 in WAIT state):
  - Next edge: state = IDLE; mem_request = 0.
  - For reads: read_data = extracted lane, sign-extended unless load_unsigned; read_valid pulses for 1 cycle.
  - Writes produce no read_valid.
  - Load latency: read_data is valid 1 cycle after ack.
- Timeout:
  - When counter = MAX_WAIT and mem_ack = 0: next edge state = IDLE, mem_request = 0, timeout pulses.
  - A read abort sets read_data = 0 and produces no read_valid.
  - mem_ack in the same cycle as counter = MAX_WAIT counts as completion, not timeout.
- mem_ack while IDLE: ignored.
- pad_read / pad_write while not IDLE: ignored (stall prevents them in normal operation).
- Reset mid-transaction: next edge mem_request = 0, state = IDLE, no read_valid or timeout pulse.
- load_unsigned and pad_data_size are captured at accept; later changes do not affect the extension.

Test Plan:
- Byte load, signed: latch 0x0000_1003, pad_read, size 00, load_unsigned 0; mem returns 0x80FF_FF7F with ack after 2 cycles -> mem_address 0x0000_1000, byte_enable 1000, stall high 3 cycles, read_data 0xFFFF_FF80, read_valid 1 pulse.
- Unsigned half load: addr 0x2002, size 01, load_unsigned 1, mem 0xBEEF_1234, immediate ack -> byte_enable 1100, read_data 0x0000_BEEF.
- Byte store: addr 0x41, wd 0x0000_00A5, size 00, pad_write -> mem_write_enable 1, byte_enable 0010, mem_write_data 0xA5A5_A5A5, no read_valid.
- Misaligned word: addr 0x102, size 11, pad_read -> misaligned pulse, mem_request never 1, read_data unchanged.
- Timeout with MAX_WAIT = 4, no ack -> mem_request high 5 cycles, timeout pulse, read_data 0. Repeat with ack on the 5th cycle -> completes normally, no timeout.
- Reset asserted in READ_WAIT cycle 2 -> next cycle mem_request 0, stall 0, read_valid 0. A following read at 0x0 completes normally.
